serial_read_fifo: RTL and testbench

SERIAL_READ_FIFO -- requirements
Module: serial_read_fifo

---
 rtl/serial_read_fifo.sv | 189 ++++++++++++++++++
 tb/tb_serial_read_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_read_fifo.sv
// Serial-to-parallel receiver: shifts bits in on read_sig strobes and queues the completed words in a small FIFO.
// Optional macro SERIAL_READ_FIFO_PARITY_EN adds one trailing even-parity bit per word.
module serial_read_fifo #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 16,
    parameter int LSB_FIRST  = 0
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   num_words,
    input  logic                             read_sig,
    input  logic                             data_in,
    input  logic                             abort,
    input  logic                             rd_en,
    output logic [WORD_SIZE-1:0]             data_out,
    output logic                             data_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             parity_err
);
    localparam int NW_W  = $clog2(MAX_WORDS+1);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(WORD_SIZE+1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
`ifdef SERIAL_READ_FIFO_PARITY_EN
    localparam logic [1:0] PAR  = 2'd2;
`endif

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] shift_reg;
    logic [WORD_SIZE-1:0] shift_nxt;
    logic [WORD_SIZE-1:0] push_word;
    logic [BC_W-1:0]      bit_cnt;
    logic [NW_W-1:0]      word_cnt;
    logic [NW_W-1:0]      word_target;
    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 bit_stb;
    logic                 last_bit;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 last_word;
    logic                 start_ok;

    function automatic logic [WORD_SIZE-1:0] shift_in(input logic [WORD_SIZE-1:0] cur,
                                                      input logic d);
        if (LSB_FIRST != 0)
            return (cur >> 1) | (WORD_SIZE'(d) << (WORD_SIZE-1));
        else
            return (cur << 1) | WORD_SIZE'(d);
    endfunction

    always_comb begin
        bit_stb   = read_sig && !abort && (state == RECV);
        last_bit  = bit_stb && (bit_cnt == BC_W'(WORD_SIZE-1));
        shift_nxt = shift_in(shift_reg, data_in);
`ifdef SERIAL_READ_FIFO_PARITY_EN
        // Word is committed only once its parity bit has arrived.
        push_req  = read_sig && !abort && (state == PAR);
        push_word = shift_reg;
`else
        push_req  = last_bit;
        push_word = shift_nxt;
`endif
        pop       = rd_en && (count != '0);
        push_ok   = push_req && ((count != CNT_W'(FIFO_DEPTH)) || pop);
        last_word = (word_cnt + NW_W'(1)) == word_target;
        start_ok  = start && (state == IDLE) && (num_words <= NW_W'(MAX_WORDS));
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            word_target <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
`ifdef SERIAL_READ_FIFO_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        overflow    <= 1'b0;
`ifdef SERIAL_READ_FIFO_PARITY_EN
                        parity_err  <= 1'b0;
`endif
                        word_target <= num_words;
                        word_cnt    <= '0;
                        bit_cnt     <= '0;
                        shift_reg   <= '0;
                        if (num_words == '0)
                            done <= 1'b1;
                        else
                            state <= RECV;
                    end
                end
                RECV: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (bit_stb) begin
                        shift_reg <= shift_nxt;
                        if (last_bit) begin
                            bit_cnt <= '0;
`ifdef SERIAL_READ_FIFO_PARITY_EN
                            state   <= PAR;
`else
                            word_cnt <= word_cnt + NW_W'(1);
                            if (last_word) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
`ifdef SERIAL_READ_FIFO_PARITY_EN
                PAR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (read_sig) begin
                        if ((^shift_reg) != data_in)
                            parity_err <= 1'b1;
                        word_cnt <= word_cnt + NW_W'(1);
                        if (last_word) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_word;
    end

    assign data_out   = (count != '0) ? mem[rd_ptr] : '0;
    assign data_valid = (count != '0);
    assign fifo_count = count;
    assign busy       = (state != IDLE);
`ifndef SERIAL_READ_FIFO_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_read_fifo.sv
// Randomized bench for serial_read_fifo against a queue-based reference model.
// Adapts to SERIAL_READ_FIFO_PARITY_EN when that macro is defined for the build.
module tb_serial_read_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_l;
    logic [4:0] num_words;
    logic       read_sig;
    logic       data_in;
    logic       abort;
    logic       rd_en;
    logic       rd_en_l;

    logic [7:0] data_out,   data_out_l;
    logic       data_valid, data_valid_l;
    logic [2:0] fifo_count, fifo_count_l;
    logic       busy, busy_l, done, done_l;
    logic       overflow, overflow_l, parity_err, parity_err_l;

    always #5 clk = ~clk;

    serial_read_fifo #(.WORD_SIZE(8), .FIFO_DEPTH(DEPTH), .MAX_WORDS(16), .LSB_FIRST(0)) dut (
        .sys_clk(clk), .rst(rst), .start(start), .num_words(num_words), .read_sig(read_sig),
        .data_in(data_in), .abort(abort), .rd_en(rd_en), .data_out(data_out),
        .data_valid(data_valid), .fifo_count(fifo_count), .busy(busy), .done(done),
        .overflow(overflow), .parity_err(parity_err)
    );

    serial_read_fifo #(.WORD_SIZE(8), .FIFO_DEPTH(DEPTH), .MAX_WORDS(16), .LSB_FIRST(1)) dut_lsb (
        .sys_clk(clk), .rst(rst), .start(start_l), .num_words(num_words), .read_sig(read_sig),
        .data_in(data_in), .abort(abort), .rd_en(rd_en_l), .data_out(data_out_l),
        .data_valid(data_valid_l), .fifo_count(fifo_count_l), .busy(busy_l), .done(done_l),
        .overflow(overflow_l), .parity_err(parity_err_l)
    );

    logic [7:0] exp_q[$];
    bit exp_busy, exp_done, exp_ovf, exp_perr;
    int n_cmp = 0;
    int n_bad = 0;
    int pop_rate = 0;
    bit pop_at_push = 0;
    bit start_noise = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("fifo_count", fifo_count, exp_q.size());
        check("data_valid", data_valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check("data_out", data_out, exp_q[0]);
        check("overflow", overflow, exp_ovf);
        check("parity_err", parity_err, exp_perr);
    endtask

    task automatic drive_rd();
        rd_en = ($urandom_range(0, 99) < pop_rate);
    endtask

    // One clock: model pops first, then accepts or drops the pushed word.
    task automatic tick(input bit push_evt, input logic [7:0] pw, input bit nb, input bit nd);
        bit pop;
        pop = rd_en && (exp_q.size() > 0);
        @(posedge clk);
        if (pop)
            void'(exp_q.pop_front());
        if (push_evt) begin
            if (exp_q.size() < DEPTH)
                exp_q.push_back(pw);
            else
                exp_ovf = 1'b1;
        end
        exp_busy = nb;
        exp_done = nd;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; start_l = 1'b0; read_sig = 1'b0;
        abort = 1'b0; rd_en = 1'b0; rd_en_l = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_busy = 0; exp_done = 0; exp_ovf = 0; exp_perr = 0;
        check_outputs();
        check("rst_data_out", data_out, 0);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            read_sig = 1'($urandom_range(0, 1));
            data_in  = 1'($urandom_range(0, 1));
            drive_rd();
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            read_sig = 1'b0;
        end
    endtask

    task automatic begin_txn(input int n);
        start = 1'b1;
        num_words = 5'(n);
        read_sig = 1'b0;
        drive_rd();
        exp_ovf = 0;
        exp_perr = 0;
        tick(1'b0, 8'h00, n != 0, n == 0);
        start = 1'b0;
    endtask

    task automatic gaps(input int max_gap);
        int n;
        n = $urandom_range(0, max_gap);
        for (int k = 0; k < n; k++) begin
            read_sig = 1'b0;
            drive_rd();
            if (start_noise && exp_busy && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                num_words = 5'($urandom_range(0, 16));
            end
            tick(1'b0, 8'h00, exp_busy, 1'b0);
            start = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit last, input bit bad_par, input int max_gap);
        bit push_here;
        for (int i = 0; i < 8; i++) begin
            gaps(max_gap);
            read_sig = 1'b1;
            data_in  = w[7-i];
            drive_rd();
`ifdef SERIAL_READ_FIFO_PARITY_EN
            push_here = 1'b0;
`else
            push_here = (i == 7);
`endif
            if (push_here && pop_at_push)
                rd_en = 1'b1;
            tick(push_here, w, push_here ? !last : 1'b1, push_here && last);
            read_sig = 1'b0;
        end
`ifdef SERIAL_READ_FIFO_PARITY_EN
        gaps(max_gap);
        read_sig = 1'b1;
        data_in  = (^w) ^ bad_par;
        drive_rd();
        if (pop_at_push)
            rd_en = 1'b1;
        if (bad_par)
            exp_perr = 1'b1;
        tick(1'b1, w, !last, last);
        read_sig = 1'b0;
`endif
    endtask

    task automatic pop_all();
        for (int k = 0; k < DEPTH + 2 && exp_q.size() > 0; k++) begin
            rd_en = 1'b1;
            tick(1'b0, 8'h00, exp_busy, 1'b0);
        end
        rd_en = 1'b0;
        check("drained", fifo_count, 0);
    endtask

    initial begin
        logic [7:0] w;
        int n;
        num_words = '0;
        data_in = 1'b0;
        do_reset();
        do_reset();

        // Three MSB-first words, no pops, then drain in order.
        begin_txn(3);
        send_word(8'h3A, 1'b0, 1'b0, 1);
        send_word(8'h71, 1'b0, 1'b0, 1);
        send_word(8'hF0, 1'b1, 1'b0, 1);
        idle(1);
        pop_all();

        // Zero-word start: done only.
        begin_txn(0);
        idle(2);

        // LSB-first instance receives 0x3A.
        start_l = 1'b1; num_words = 5'd1; rd_en = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        start_l = 1'b0;
        check("lsb_busy", busy_l, 1);
        w = 8'h3A;
        for (int i = 0; i < 8; i++) begin
            read_sig = 1'b1; data_in = w[i];
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
`ifdef SERIAL_READ_FIFO_PARITY_EN
        data_in = ^w;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
`endif
        read_sig = 1'b0;
        check("lsb_done", done_l, 1);
        check("lsb_busy_end", busy_l, 0);
        check("lsb_valid", data_valid_l, 1);
        check("lsb_data", data_out_l, 8'h3A);
        rd_en_l = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        rd_en_l = 1'b0;
        check("lsb_empty", data_valid_l, 0);

        // Overflow: six words into a four-deep FIFO.
        pop_rate = 0;
        begin_txn(6);
        for (int k = 1; k <= 6; k++)
            send_word(8'(k), k == 6, 1'b0, 0);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        pop_all();
        begin_txn(1);
        check("ovf_cleared", overflow, 0);
        send_word(8'h5A, 1'b1, 1'b0, 0);
        pop_all();

        // Full FIFO with a pop on the push edge: no overflow.
        begin_txn(5);
        for (int k = 0; k < 4; k++)
            send_word(8'h11 + 8'(k), 1'b0, 1'b0, 0);
        pop_at_push = 1;
        send_word(8'h15, 1'b1, 1'b0, 0);
        pop_at_push = 0;
        check("full_pushpop_ovf", overflow, 0);
        pop_all();

        // Reset after three bits of the second word.
        begin_txn(3);
        send_word(8'h3A, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            read_sig = 1'b1; data_in = w[7-i];
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        do_reset();
        idle(2);
        begin_txn(1);
        send_word(8'h71, 1'b1, 1'b0, 0);
        pop_all();

        // Abort after one word plus five bits.
        begin_txn(3);
        send_word(8'hC5, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            read_sig = 1'b1; data_in = 1'($urandom_range(0, 1));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        read_sig = 1'b0; abort = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        abort = 1'b0;
        check("abort_count", fifo_count, 1);
        idle(2);
        pop_all();

        // Abort coinciding with the completing bit wins.
        begin_txn(1);
        for (int i = 0; i < 7; i++) begin
            read_sig = 1'b1; data_in = 1'b1;
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        abort = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        abort = 1'b0; read_sig = 1'b0;
        idle(2);

        // Parity: bad bit flags, good bit does not; the word is kept either way.
        begin_txn(1);
        send_word(8'h3A, 1'b1, 1'b1, 0);
        pop_all();
        begin_txn(1);
        send_word(8'h3A, 1'b1, 1'b0, 0);
        pop_all();

        // Randomized transactions with random pops, gaps and ignored starts.
        start_noise = 1;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 8);
            pop_rate = $urandom_range(0, 70);
            begin_txn(n);
            for (int k = 0; k < n; k++)
                send_word(8'($urandom), k == n - 1, $urandom_range(0, 4) == 0, 2);
            idle($urandom_range(1, 3));
        end
        pop_rate = 0;
        start_noise = 0;
        pop_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
